// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the ALU share arbiter and its environment: both request
// channels, the ALU-facing signals, the response channel and the busy flag.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3
);
    logic             req0_valid;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic             alu_inva;
    logic             alu_invb;
    logic [WIDTH-1:0] alu_out;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;

    logic             busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_op, alu_a, alu_b, alu_cin, alu_inva, alu_invb,
        input  rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_out, rsp_ready,
        output req0_ready, req1_ready,
        output alu_op, alu_a, alu_b, alu_cin, alu_inva, alu_invb,
        output rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one execute-stage ALU between two requesters. One operation is in
// flight at a time: accept (IDLE), drive the ALU for one cycle (EXEC), then
// hold the tagged result until the consumer takes it (RESP).
// Optional feature: define ALU_ARB_RR_EN for round-robin tie breaking;
// otherwise port 0 always wins a tie.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OPW   = 3
) (
    input logic               clk,
    input logic               rst,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    localparam logic [OPW-1:0] OpSubCin = OPW'(1);  // a + ~b + 1
    localparam logic [OPW-1:0] OpSubNc  = OPW'(3);  // a + ~b

    state_e           state_q, state_d;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic             id_q;

    logic             tie_to_1;
    logic             grant0;
    logic             grant1;
    logic             accept;

`ifdef ALU_ARB_RR_EN
    logic ptr_q;

    // Pointer flips to the port that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= ~grant1;
        end
    end

    assign tie_to_1 = ptr_q;
`else
    assign tie_to_1 = 1'b0;
`endif

    // Grant selection and acceptance handshake, only offered in IDLE.
    always_comb begin
        grant1         = bus.req1_valid && (!bus.req0_valid || tie_to_1);
        grant0         = bus.req0_valid && !grant1;
        bus.req0_ready = (state_q == StIdle) && grant0;
        bus.req1_ready = (state_q == StIdle) && grant1;
        accept         = bus.req0_ready || bus.req1_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and ALU drive; ALU inputs stay quiet outside EXEC.
    always_comb begin
        state_d      = state_q;
        bus.alu_op   = '0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_cin  = 1'b0;
        bus.alu_inva = 1'b0;
        bus.alu_invb = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                bus.alu_op   = op_q;
                bus.alu_a    = a_q;
                bus.alu_b    = b_q;
                bus.alu_cin  = (op_q == OpSubCin);
                bus.alu_invb = (op_q == OpSubCin) || (op_q == OpSubNc);
                state_d      = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand latch on acceptance and result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= 1'b0;
            data_q <= '0;
        end else begin
            if (accept) begin
                op_q <= grant1 ? bus.req1_op : bus.req0_op;
                a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
                b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
                id_q <= grant1;
            end
            if (state_q == StExec) begin
                data_q <= bus.alu_out;
            end
        end
    end

    // Response channel and status.
    always_comb begin
        bus.rsp_valid = (state_q == StResp);
        bus.rsp_id    = id_q;
        bus.rsp_data  = data_q;
        bus.busy      = (state_q != StIdle);
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small ALU model on alu_out.
// Expected values are hand-computed; honours ALU_ARB_RR_EN for tie results.
module tb_alu_share_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_share_arbiter_if #(.WIDTH(16), .OPW(3)) bus ();

    alu_share_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: op[2] set -> xor, otherwise add with invert/carry controls.
    always_comb begin
        logic [15:0] x;
        logic [15:0] y;
        x = bus.alu_inva ? ~bus.alu_a : bus.alu_a;
        y = bus.alu_invb ? ~bus.alu_b : bus.alu_b;
        if (bus.alu_op[2]) bus.alu_out = bus.alu_a ^ bus.alu_b;
        else               bus.alu_out = x + y + {15'd0, bus.alu_cin};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " alu_op"}, 32'(bus.alu_op), 0);
        chk({tag, " alu_a"}, 32'(bus.alu_a), 0);
        chk({tag, " alu_b"}, 32'(bus.alu_b), 0);
        chk({tag, " alu_cin"}, 32'(bus.alu_cin), 0);
        chk({tag, " alu_invb"}, 32'(bus.alu_invb), 0);
        chk({tag, " alu_inva"}, 32'(bus.alu_inva), 0);
    endtask

    // Full operation through port 1 with control decode and result checks.
    task automatic op_port1(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic invb, input logic [15:0] res);
        bus.req1_valid = 1'b1;
        bus.req1_op    = op;
        bus.req1_a     = a;
        bus.req1_b     = b;
        #1;
        chk("p1 ready", 32'(bus.req1_ready), 1);
        chk("p1 ready0", 32'(bus.req0_ready), 0);
        step();
        bus.req1_valid = 1'b0;
        #1;
        chk("exec op", 32'(bus.alu_op), 32'(op));
        chk("exec cin", 32'(bus.alu_cin), 32'(cin));
        chk("exec invb", 32'(bus.alu_invb), 32'(invb));
        chk("exec inva", 32'(bus.alu_inva), 0);
        step();
        chk("resp valid", 32'(bus.rsp_valid), 1);
        chk("resp id", 32'(bus.rsp_id), 1);
        chk("resp data", 32'(bus.rsp_data), 32'(res));
        chk_quiet("resp");
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        #1;
        chk("idle busy", 32'(bus.busy), 0);
        chk_quiet("idle");
    endtask

    initial begin
        logic [3:0] tie_exp;
        n_cmp          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_op    = '0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_op    = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.rsp_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst req0_ready", 32'(bus.req0_ready), 0);
        chk("rst req1_ready", 32'(bus.req1_ready), 0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst rsp_id", 32'(bus.rsp_id), 0);
        chk("rst rsp_data", 32'(bus.rsp_data), 0);
        chk("rst busy", 32'(bus.busy), 0);
        chk_quiet("rst");

        // Single op on port 0: 5 + ~3 + 1 = 2; operand change after accept ignored
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b001;
        bus.req0_a     = 16'h0005;
        bus.req0_b     = 16'h0003;
        #1;
        chk("single ready0", 32'(bus.req0_ready), 1);
        chk("single ready1", 32'(bus.req1_ready), 0);
        step();
        bus.req0_valid = 1'b0;
        bus.req0_a     = 16'hFFFF;
        #1;
        chk("single busy", 32'(bus.busy), 1);
        chk("single alu_a", 32'(bus.alu_a), 32'h5);
        chk("single alu_b", 32'(bus.alu_b), 32'h3);
        chk("single cin", 32'(bus.alu_cin), 1);
        chk("single invb", 32'(bus.alu_invb), 1);
        chk("single rsp_valid early", 32'(bus.rsp_valid), 0);
        step();
        chk("single rsp_valid", 32'(bus.rsp_valid), 1);
        chk("single rsp_id", 32'(bus.rsp_id), 0);
        chk("single rsp_data", 32'(bus.rsp_data), 32'h2);

        // Backpressure: requests pending, rsp_ready low for 5 cycles
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp rsp_valid", 32'(bus.rsp_valid), 1);
            chk("bp rsp_data", 32'(bus.rsp_data), 32'h2);
            chk("bp rsp_id", 32'(bus.rsp_id), 0);
            chk("bp busy", 32'(bus.busy), 1);
            chk("bp ready0", 32'(bus.req0_ready), 0);
            chk("bp ready1", 32'(bus.req1_ready), 0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("bp release rsp_valid", 32'(bus.rsp_valid), 0);
        chk("bp release busy", 32'(bus.busy), 0);

        // Control decode through port 1
        op_port1(3'b000, 16'h1234, 16'h0101, 1'b0, 1'b0, 16'h1335);
        op_port1(3'b001, 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F);
        op_port1(3'b011, 16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000E);
        op_port1(3'b111, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 16'h0FF0);

        // Tie: both valid continuously, consumer always ready
`ifdef ALU_ARB_RR_EN
        tie_exp = 4'b1010;  // bit i = expected id of op i
`else
        tie_exp = 4'b0000;
`endif
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b000;
        bus.req0_a     = 16'h0100;
        bus.req0_b     = 16'h0001;
        bus.req1_valid = 1'b1;
        bus.req1_op    = 3'b000;
        bus.req1_a     = 16'h0200;
        bus.req1_b     = 16'h0002;
        bus.rsp_ready  = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("tie ready0", 32'(bus.req0_ready), 32'(!tie_exp[i]));
            chk("tie ready1", 32'(bus.req1_ready), 32'(tie_exp[i]));
            step();
            step();
            chk("tie rsp_id", 32'(bus.rsp_id), 32'(tie_exp[i]));
            chk("tie rsp_data", 32'(bus.rsp_data), tie_exp[i] ? 32'h0202 : 32'h0101);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        step();

        // Reset mid-op in EXEC; port 0 served so an RR pointer would point at port 1
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b001;
        bus.req0_a     = 16'h0009;
        bus.req0_b     = 16'h0004;
        step();
        bus.req0_valid = 1'b0;
        #1;
        chk("mid exec cin", 32'(bus.alu_cin), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mid rst busy", 32'(bus.busy), 0);
        chk_quiet("mid rst");
        bus.req0_valid = 1'b1;
        bus.req0_op    = 3'b000;
        bus.req0_a     = 16'h0003;
        bus.req0_b     = 16'h0004;
        bus.req1_valid = 1'b1;
        #1;
        chk("post rst ready0", 32'(bus.req0_ready), 1);
        chk("post rst ready1", 32'(bus.req1_ready), 0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        chk("post rst rsp_id", 32'(bus.rsp_id), 0);
        chk("post rst rsp_data", 32'(bus.rsp_data), 32'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and arbiter that shares the single execute-stage ALU between two requesters (port 0: main execute path, port 1: address/branch unit). Accepts one operation at a time through a valid/ready handshake, drives the ALU operands and carry/invert configuration for one cycle, captures the result, and returns it on a single response channel tagged with the requester ID. It sits between the decode/execute control logic and the ALU instance.

## Interface
- WIDTH, 16, operand and result width in bits
- OPW, 3, ALU opcode width
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_op  in  OPW  requester 0 ALU opcode
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req1_valid, req1_op, req1_a, req1_b, req1_ready  as port 0, for requester 1
- alu_op  out  OPW  opcode to ALU
- alu_a, alu_b  out  WIDTH  operands to ALU
- alu_cin, alu_inva, alu_invb  out  1  ALU carry-in / operand-invert controls
- alu_out  in  WIDTH  combinational ALU result
- rsp_valid  out  1  response available
- rsp_id  out  1  requester that owns the response
- rsp_data  out  WIDTH  captured ALU result
- rsp_ready  in  1  response consumer accepts
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: reqN_ready high only for the granted requester, and only if that requester's valid is high (ready never high for both). On acceptance: latch op, a, b, id; go to EXEC.
- Grant: if only one valid, grant it. If both valid, arbitrate (see Configuration).
- EXEC: drive alu_op/alu_a/alu_b from latched values; derive controls from latched op: 3'b001 -> cin=1, invb=1; 3'b011 -> cin=0, invb=1; all others cin=0, invb=0. alu_inva always 0. On the clock edge, capture alu_out into rsp_data; go to RESP.
- RESP: rsp_valid=1, rsp_id/rsp_data stable until rsp_valid && rsp_ready, then go to IDLE. No new acceptance while in RESP.
- Outside EXEC: alu_op, alu_a, alu_b, alu_cin, alu_invb = 0 (quiet ALU inputs).
- Opcodes are opaque apart from the control derivation; any OPW value is accepted.

## Timing
- Reset values: req0_ready=0, req1_ready=0, alu_* = 0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, round-robin pointer set so port 0 wins the first tie.
- Accept at cycle N -> EXEC in N+1 -> rsp_valid high from N+2.
- rsp_ready high at N+2 -> IDLE at N+3; next accept possible at N+3. Minimum of 3 cycles per operation.
- rsp_ready held low: stay in RESP indefinitely; rsp_data/rsp_id do not change.
- Requester drops valid before acceptance: no effect, nothing latched.
- rst asserted in any state: next cycle IDLE, in-flight operation dropped, rsp_valid=0, arbitration pointer reset.
- Request operands sampled only on the acceptance edge; later changes ignored.

## Configuration
- ALU_ARB_RR_EN defined: round-robin on a tie. The pointer updates on each acceptance so that the other port wins the next tie.
- ALU_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie. Port 1 is served only when req0_valid is low in IDLE. The pointer logic is not built.

## Test plan
- Single op: req0 op=001, a=0x0005, b=0x0003 at cycle 1 -> req0_ready=1 at cycle 1; alu_cin=1, alu_invb=1 at cycle 2; rsp_valid=1, rsp_id=0, rsp_data=ALU result at cycle 3.
- Control decode: ops 000, 001, 011, 111 through port 1 -> (cin,invb) = (0,0), (1,1), (0,1), (0,0) in EXEC; alu_inva=0 throughout; alu_* = 0 in IDLE/RESP.
- Tie, RR enabled: both valid continuously for 4 ops -> rsp_id sequence 0,1,0,1. RR disabled -> 0,0,0,0 and req1_ready never high.
- Backpressure: rsp_ready low 5 cycles after rsp_valid -> rsp_data/rsp_id constant, busy=1, both ready=0; rsp_ready=1 -> IDLE next cycle.
- Reset mid-op: rst in EXEC -> next cycle rsp_valid=0, busy=0, alu_*=0; a subsequent tie grants port 0.
- Operand hold: change req0_a after acceptance -> rsp_data reflects the operands latched at acceptance.
